cycle_count_uart_tx: RTL and testbench

Downstream consumer of the clock divider's `clkcount` output. When the processor drops `busy`, this block snapshots the 32-bit cycle count. It then streams the count over a UART TX line as 8 uppercase ASCII hex digits followed by CR LF. It lets the board report measured run time to a host terminal without a debugger.

---
 rtl/cycle_count_uart_tx_pkg.sv | 26 ++
 rtl/cycle_count_uart_tx_if.sv | 26 ++
 rtl/cycle_count_uart_tx_byte.sv | 108 ++++++++++
 rtl/cycle_count_uart_tx.sv | 121 ++++++++++++
 tb/tb_cycle_count_uart_tx.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cycle_count_uart_tx_pkg.sv
// Shared types and helpers for the cycle-count UART reporter.
package cycle_count_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

endpackage

// File: rtl/cycle_count_uart_tx_if.sv
// Processor-side and UART-side signals of the cycle-count reporter.
interface cycle_count_uart_tx_if #(
    parameter int COUNT_W = 32
) ();
    logic               busy;
    logic [COUNT_W-1:0] clkcount;
    logic               tx;
    logic               tx_active;
    logic               done;

    modport master (
        output busy,
        output clkcount,
        input  tx,
        input  tx_active,
        input  done
    );

    modport slave (
        input  busy,
        input  clkcount,
        output tx,
        output tx_active,
        output done
    );
endinterface

// File: rtl/cycle_count_uart_tx_byte.sv
// 8N1 framing of a single byte; ready is high when a new byte can be
// accepted this cycle, including the last stop-bit cycle so characters
// chain without idle gaps.
module uart_tx_byte
    import cycle_count_pkg::*;
#(
    parameter int BAUD_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    state_e          state_r, state_s;
    logic [TW-1:0]   timer_r, timer_s;
    logic [2:0]      bit_r, bit_s;
    logic [7:0]      shift_r, shift_s;
    logic            tx_r, tx_s;
    logic            tc_s;

    assign tc_s  = (timer_r == TW'(BAUD_DIV - 1));
    assign ready = (state_r == IDLE) || ((state_r == STOP) && tc_s);
    assign tx    = tx_r;

    // Next-state and next-bit computation; the bit timer only moves the frame on at terminal count.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        case (state_r)
            IDLE: begin
                timer_s = '0;
                tx_s    = 1'b1;
            end
            START: begin
                if (tc_s) begin
                    state_s = DATA;
                    timer_s = '0;
                    bit_s   = 3'd0;
                    tx_s    = shift_r[0];
                    shift_s = {1'b0, shift_r[7:1]};
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            DATA: begin
                if (tc_s) begin
                    timer_s = '0;
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        tx_s    = shift_r[0];
                        shift_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            STOP: begin
                if (tc_s) begin
                    state_s = IDLE;
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                timer_s = '0;
                tx_s    = 1'b1;
            end
        endcase
        if (start && ready) begin
            state_s = START;
            timer_s = '0;
            bit_s   = 3'd0;
            shift_s = data;
            tx_s    = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // Frame state register; reset parks the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            timer_r <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
        end
    end
endmodule

// File: rtl/cycle_count_uart_tx.sv
// Snapshots clkcount when busy falls and reports it as 8 hex digits + CR LF.
module cycle_count_uart_tx
    import cycle_count_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int COUNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    cycle_count_uart_tx_if.slave  bus
);
    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD;
    localparam int NDIG     = COUNT_W / 4;
    localparam int NCHARS   = NDIG + 2;
    localparam int IW       = $clog2(NCHARS);

    state_e             state_r, state_s;
    logic [IW-1:0]      idx_r, idx_s;
    logic [COUNT_W-1:0] snap_r, snap_s;
    logic               busy_q_r;
    logic               tx_active_r;
    logic               done_r;
    logic               fall_s;
    logic               byte_start_s;
    logic [7:0]         byte_data_s;
    logic               byte_ready_s;
    logic               byte_tx_s;

    // Character idx of the report: hex digits MSB first, then CR, then LF.
    function automatic logic [7:0] char_at(input logic [COUNT_W-1:0] v, input logic [IW-1:0] idx);
        logic [COUNT_W-1:0] sh;
        logic [7:0]         ch;
        sh = '0;
        if (idx < IW'(NDIG)) begin
            sh = v >> (COUNT_W - 4 - 4 * int'(idx));
            ch = nibble_to_hex(sh[3:0]);
        end else if (idx == IW'(NDIG)) begin
            ch = CHAR_CR;
        end else begin
            ch = CHAR_LF;
        end
        return ch;
    endfunction

    assign fall_s        = busy_q_r && !bus.busy;
    assign bus.tx        = byte_tx_s;
    assign bus.tx_active = tx_active_r;
    assign bus.done      = done_r;

    // Report sequencing: DATA means characters are in flight; a fall outside IDLE is dropped.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        snap_s       = snap_r;
        byte_start_s = 1'b0;
        byte_data_s  = 8'h00;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    snap_s       = bus.clkcount;
                    idx_s        = '0;
                    byte_start_s = 1'b1;
                    byte_data_s  = char_at(bus.clkcount, '0);
                    state_s      = DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (byte_ready_s) begin
                    if (idx_r == IW'(NCHARS - 1)) begin
                        state_s = FIN;
                    end else begin
                        idx_s        = idx_r + IW'(1);
                        byte_start_s = 1'b1;
                        byte_data_s  = char_at(snap_r, idx_r + IW'(1));
                    end
                end else begin
                    state_s = DATA;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer registers, edge detector, snapshot and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            snap_r      <= '0;
            busy_q_r    <= 1'b0;
            tx_active_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            snap_r      <= snap_s;
            busy_q_r    <= bus.busy;
            tx_active_r <= (state_s == DATA);
            done_r      <= (state_s == FIN);
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start_s),
        .data  (byte_data_s),
        .tx    (byte_tx_s),
        .ready (byte_ready_s)
    );
endmodule

// File: tb/tb_cycle_count_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes and done times,
// independent monitors decode the UART line and the done pulse.
module tb_cycle_count_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   ignore_rx = 1'b0;

    logic [7:0] exp_q[$];
    int         done_q[$];

    logic [7:0] mon_b;
    logic [7:0] mon_e;
    logic       mon_ok0;
    logic       mon_ok1;
    int         done_exp;

    cycle_count_uart_tx_if #(.COUNT_W(32)) bus ();

    cycle_count_uart_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .COUNT_W     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // UART decoder: samples each bit at its centre, 10 cycles per bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.tx === 1'b0) begin
                repeat (5) @(negedge clk);
                mon_ok0 = (bus.tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    mon_b[i] = bus.tx;
                end
                repeat (10) @(negedge clk);
                mon_ok1 = (bus.tx === 1'b1);
                if (!ignore_rx) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL uart_unexpected: got byte %02h, expected none", mon_b);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_b !== mon_e || !mon_ok0 || !mon_ok1) begin
                            n_fail++;
                            $display("FAIL uart_byte: got %02h (start_ok=%0b stop_ok=%0b), expected %02h",
                                     mon_b, mon_ok0, mon_ok1, mon_e);
                        end
                    end
                end
            end
        end
    end

    // Done monitor: each pulse must match a scheduled cycle with the line idle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n_chk++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    done_exp = done_q.pop_front();
                    if (cyc != done_exp || bus.tx_active !== 1'b0 || bus.tx !== 1'b1) begin
                        n_fail++;
                        $display("FAIL done_timing: got cycle %0d tx_active=%0b tx=%0b, expected cycle %0d tx_active=0 tx=1",
                                 cyc, bus.tx_active, bus.tx, done_exp);
                    end
                end
            end
        end
    end

    task automatic trigger(input logic [31:0] val, input logic [79:0] exp_str);
        int t;
        @(negedge clk);
        bus.clkcount = val;
        bus.busy     = 1'b1;
        @(negedge clk);
        check("pre_trigger_tx", bus.tx, 1'b1);
        bus.busy = 1'b0;
        t = cyc;
        for (int i = 9; i >= 0; i--) exp_q.push_back(exp_str[i*8 +: 8]);
        done_q.push_back(t + 1001);
        @(negedge clk);
        check("start_latency_tx", bus.tx, 1'b0);
        check("start_tx_active", bus.tx_active, 1'b1);
    endtask

    task automatic wait_report(input bit inc);
        for (int i = 0; i < 1500 && (done_q.size() != 0 || exp_q.size() != 0); i++) begin
            @(negedge clk);
            if (inc) bus.clkcount = bus.clkcount + 32'd1;
        end
        check("report_complete", 64'(done_q.size() + exp_q.size()), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        bit ok;
        bus.busy     = 1'b1;
        bus.clkcount = $urandom;

        // Reset values under active busy and random count.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.clkcount = $urandom;
            check("rst_tx", bus.tx, 1'b1);
            check("rst_tx_active", bus.tx_active, 1'b0);
            check("rst_done", bus.done, 1'b0);
        end
        bus.busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.tx_active !== 1'b0) ok = 1'b0;
        end
        check("no_tx_after_release", ok, 1'b1);

        // Basic report.
        trigger(32'h0000_0032, {"00000032", 8'h0D, 8'h0A});
        wait_report(1'b0);

        // Hex letters.
        trigger(32'hDEAD_BEEF, {"DEADBEEF", 8'h0D, 8'h0A});
        wait_report(1'b0);

        // Snapshot stability while the count keeps running.
        trigger(32'h1234_ABCD, {"1234ABCD", 8'h0D, 8'h0A});
        wait_report(1'b1);

        // Retrigger during a report is ignored.
        trigger(32'h0F0F_9A50, {"0F0F9A50", 8'h0D, 8'h0A});
        repeat (150) @(negedge clk);
        bus.busy = 1'b1;
        repeat (3) @(negedge clk);
        bus.busy = 1'b0;
        repeat (100) @(negedge clk);
        bus.busy = 1'b1;
        repeat (2) @(negedge clk);
        bus.busy = 1'b0;
        wait_report(1'b0);
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.tx_active !== 1'b0) ok = 1'b0;
        end
        check("idle_after_retrigger", ok, 1'b1);

        // Reset in the middle of the fourth character.
        trigger(32'h89AB_CDEF, {"89ABCDEF", 8'h0D, 8'h0A});
        repeat (350) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_tx", bus.tx, 1'b1);
        check("midrst_tx_active", bus.tx_active, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        ignore_rx = 1'b1;
        exp_q.delete();
        done_q.delete();
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        ignore_rx = 1'b0;
        trigger(32'hFEDC_0123, {"FEDC0123", 8'h0D, 8'h0A});
        wait_report(1'b0);

        check("final_queues_empty", 64'(exp_q.size() + done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
